// File: rtl/reset_sequencer.sv
// Board reset sequencer: waits for clock lock, holds the PHY in reset, settles, then releases core_rst.
// Optional lock-loss monitor and saturating counter enabled by defining RST_SEQ_LOCK_MONITOR_EN.
module reset_sequencer #(
  parameter int PHY_RST_CYCLES = 1000000,
  parameter int SETTLE_CYCLES  = 2000000,
  parameter int CNT_W          = 24,
  parameter int LOCK_SYNC_N    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       phy_rst_n,
  output logic       core_rst,
  output logic       seq_done,
  output logic [1:0] seq_state
`ifdef RST_SEQ_LOCK_MONITOR_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    PHY_RST   = 2'b01,
    SETTLE    = 2'b10,
    RUN       = 2'b11
  } state_t;

  if (PHY_RST_CYCLES < 1) begin : g_chk_phy_min
    $error("reset_sequencer: PHY_RST_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_chk_settle_min
    $error("reset_sequencer: SETTLE_CYCLES must be >= 1");
  end
  if ((longint'(PHY_RST_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_chk_phy_fit
    $error("reset_sequencer: PHY_RST_CYCLES-1 does not fit in CNT_W bits");
  end
  if ((longint'(SETTLE_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_chk_settle_fit
    $error("reset_sequencer: SETTLE_CYCLES-1 does not fit in CNT_W bits");
  end
  if (LOCK_SYNC_N < 2) begin : g_chk_sync
    $error("reset_sequencer: LOCK_SYNC_N must be >= 2");
  end

  localparam logic [CNT_W-1:0] PHY_LAST    = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [LOCK_SYNC_N-1:0] lock_sync;
  logic                   locked_s;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   phy_rst_n_nxt, core_rst_nxt, seq_done_nxt;
`ifdef RST_SEQ_LOCK_MONITOR_EN
  logic                   lock_loss_evt;
`endif

  // Lock synchronizer: the only consumer of the raw asynchronous locked input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_sync <= '0;
    else        lock_sync <= {lock_sync[LOCK_SYNC_N-2:0], locked};
  end

  assign locked_s = lock_sync[LOCK_SYNC_N-1];

  // Next-state and counter decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
`ifdef RST_SEQ_LOCK_MONITOR_EN
    lock_loss_evt = 1'b0;
`endif
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (locked_s) state_nxt = PHY_RST;
      end
      PHY_RST: begin
        if (cnt == PHY_LAST) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      default: cnt_nxt = '0;
    endcase
`ifdef RST_SEQ_LOCK_MONITOR_EN
    // Losing lock overrides any terminal count on the same edge
    if ((state != WAIT_LOCK) && !locked_s) begin
      state_nxt     = WAIT_LOCK;
      cnt_nxt       = '0;
      lock_loss_evt = 1'b1;
    end
`endif
  end

  // Output decode from next state so ports flip on the same edge as seq_state
  always_comb begin
    phy_rst_n_nxt = 1'b0;
    core_rst_nxt  = 1'b1;
    seq_done_nxt  = 1'b0;
    case (state_nxt)
      SETTLE: phy_rst_n_nxt = 1'b1;
      RUN: begin
        phy_rst_n_nxt = 1'b1;
        core_rst_nxt  = 1'b0;
        seq_done_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      phy_rst_n <= 1'b0;
      core_rst  <= 1'b1;
      seq_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      phy_rst_n <= phy_rst_n_nxt;
      core_rst  <= core_rst_nxt;
      seq_done  <= seq_done_nxt;
    end
  end

  assign seq_state = state;

`ifdef RST_SEQ_LOCK_MONITOR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   lock_loss_cnt <= 8'h00;
    else if (lock_loss_evt && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'h01;
  end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with a per-edge expectation scoreboard.
// Exercises the lock monitor when RST_SEQ_LOCK_MONITOR_EN is defined, the lock-ignore path otherwise.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       phy_rst_n, core_rst, seq_done;
  logic [1:0] seq_state;
`ifdef RST_SEQ_LOCK_MONITOR_EN
  logic [7:0] lock_loss_cnt;
`endif

  reset_sequencer #(
    .PHY_RST_CYCLES(8),
    .SETTLE_CYCLES (5),
    .CNT_W         (4),
    .LOCK_SYNC_N   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .locked   (locked),
    .phy_rst_n(phy_rst_n),
    .core_rst (core_rst),
    .seq_done (seq_done),
    .seq_state(seq_state)
`ifdef RST_SEQ_LOCK_MONITOR_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         at;
    int         tnum;
    logic [1:0] st;
    logic       phy;
    logic       core;
    logic       done;
    logic [7:0] ll;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         edge_cnt = 0;
  logic [7:0] exp_ll = 8'h00;

  function automatic logic [12:0] obs();
`ifdef RST_SEQ_LOCK_MONITOR_EN
    return {seq_state, phy_rst_n, core_rst, seq_done, lock_loss_cnt};
`else
    return {seq_state, phy_rst_n, core_rst, seq_done, 8'h00};
`endif
  endfunction

  // Expected outputs for a state: 0 WAIT_LOCK, 1 PHY_RST, 2 SETTLE, 3 RUN
  function automatic exp_t mk(int at, int tnum, int code);
    exp_t e;
    e.at   = at;
    e.tnum = tnum;
    e.st   = 2'(code);
    e.phy  = (code >= 2);
    e.core = (code != 3);
    e.done = (code == 3);
    e.ll   = exp_ll;
    return e;
  endfunction

  task automatic push(int at, int tnum, int code);
    sb.push_back(mk(at, tnum, code));
  endtask

  task automatic check(exp_t e);
    logic [12:0] o;
    logic [12:0] x;
    o = obs();
    x = {e.st, e.phy, e.core, e.done, e.ll};
    n_tests++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL t%0d edge %0d {state,phy_rst_n,core_rst,seq_done,lock_loss}: observed %b expected %b",
             e.tnum, edge_cnt, o, x);
    end
  endtask

  task automatic run_edges(int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      edge_cnt++;
      #1;
      while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
        e = sb.pop_front();
        check(e);
      end
    end
  endtask

  // Full sequence after locked_s source goes high just after edge e0
  task automatic push_seq(int e0, int tnum);
    push(e0 + 2,  tnum, 0);
    push(e0 + 3,  tnum, 1);
    push(e0 + 10, tnum, 1);
    push(e0 + 11, tnum, 2);
    push(e0 + 15, tnum, 2);
    push(e0 + 16, tnum, 3);
    push(e0 + 20, tnum, 3);
  endtask

  initial begin
    int e0;

    // Test 1: held in reset with lock present
    rst_n  = 1'b0;
    locked = 1'b1;
    push(1, 1, 0);
    push(3, 1, 0);
    push(5, 1, 0);
    run_edges(5);

    // Test 2: release with lock already present
    rst_n = 1'b1;
    e0 = edge_cnt;
    push_seq(e0, 2);
    run_edges(21);

    // Test 3: no lock for 100 cycles, then lock rises
    rst_n  = 1'b0;
    locked = 1'b0;
    #2;
    check(mk(edge_cnt, 3, 0));
    rst_n = 1'b1;
    e0 = edge_cnt;
    push(e0 + 1,   3, 0);
    push(e0 + 25,  3, 0);
    push(e0 + 50,  3, 0);
    push(e0 + 100, 3, 0);
    run_edges(100);
    locked = 1'b1;
    e0 = edge_cnt;
    push_seq(e0, 3);
    run_edges(21);

    // Test 4: 1 ns reset pulse in the middle of SETTLE
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    e0 = edge_cnt;
    push(e0 + 11, 4, 2);
    push(e0 + 13, 4, 2);
    run_edges(13);
    #2;
    rst_n = 1'b0;
    #1;
    check(mk(edge_cnt, 4, 0));
    rst_n = 1'b1;
    e0 = edge_cnt;
    push_seq(e0, 4);
    run_edges(21);

`ifdef RST_SEQ_LOCK_MONITOR_EN
    // Test 5: lock loss in RUN, then saturation of the loss counter
    locked = 1'b0;
    e0 = edge_cnt;
    push(e0 + 2, 5, 3);
    exp_ll = 8'd1;
    push(e0 + 3, 5, 0);
    run_edges(4);
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      run_edges(4);
      locked = 1'b0;
      run_edges(3);
    end
    exp_ll = 8'd255;
    push(edge_cnt + 1, 5, 0);
    run_edges(1);
`else
    // Test 6: lock loss in SETTLE is ignored
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    e0 = edge_cnt;
    push(e0 + 11, 6, 2);
    run_edges(12);
    locked = 1'b0;
    push(e0 + 15, 6, 2);
    push(e0 + 16, 6, 3);
    push(e0 + 25, 6, 3);
    run_edges(14);
`endif

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
